nibbler_sequencer: RTL and testbench
====================================

NIBBLER_SEQUENCER -- requirements
Module: nibbler_sequencer

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum memory-stall cycles before the block aborts.
REQ-002 clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 run  in  1  free-run enable, sampled at each instruction boundary.
REQ-005 halt_req  in  1  request to stop at the next instruction boundary.
REQ-006 instr_in  in  8  program byte: [7:4] opcode, [3:0] operand.
REQ-007 c_in, z_in  in  1 each  ALU carry and zero results.
REQ-008 load_flag  in  1  flag-load bit from the microcode decoder.
REQ-009 mem_ready  in  1  RAM access-complete handshake.
REQ-010 phase  out  1  0 = fetch, 1 = execute; drives the decoder phase input.
REQ-011 opcode, operand  out  4 each  latched instruction fields.
REQ-012 flag_c, flag_z  out  1 each  latched flags.
REQ-013 ctrl_en  out  1  when high, decoder control strobes (load, PC increment) are honoured.
REQ-014 busy, halted, timeout_err  out  1 each  status outputs.
REQ-015 instr_count  out  8  count of completed instructions.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FETCH, EXEC, HALT.
REQ-017 IDLE: phase=0, ctrl_en=0, busy=0; run=1 and halt_req=0 SHALL go to FETCH next cycle.
REQ-018 FETCH: phase=0, ctrl_en=1, busy=1; instr_in SHALL latch into opcode/operand at cycle end; next state is EXEC.
REQ-019 EXEC: phase=1; memory opcodes are {3,6,7,11,15}; for these, ctrl_en SHALL equal mem_ready; for all other opcodes, ctrl_en=1.
REQ-020 EXEC with ctrl_en=0 SHALL remain in EXEC and increment a wait counter; opcode, operand and flags SHALL hold.
REQ-021 EXEC with ctrl_en=1 completes the instruction:
  - instr_count increments (wraps 255->0);
  - the wait counter clears;
  - if load_flag=1, flag_c<=c_in and flag_z<=z_in.
REQ-022 Next state after completion:
  - HALT if halt_req=1;
  - else FETCH if run=1;
  - else IDLE.
REQ-023 A wait counter equal to WAIT_MAX while stalled SHALL force HALT next cycle, set timeout_err=1 and leave flags and instr_count unchanged.
REQ-024 HALT: halted=1, ctrl_en=0, phase=0, busy=0; HALT SHALL be left only via reset.
REQ-025 halt_req SHALL be ignored mid-instruction (FETCH, stalled EXEC) and honoured only at the boundary; in IDLE, halt_req=1 SHALL go to HALT.
REQ-026 Single-cycle-latency instructions SHALL take exactly 2 clocks (FETCH+EXEC); each stall cycle adds 1.

Reset
REQ-027 reset SHALL dominate all inputs and force IDLE with:
  - phase=0, opcode=0, operand=0, flag_c=0, flag_z=0;
  - ctrl_en=0, busy=0, halted=0, timeout_err=0;
  - instr_count=0, wait counter=0.
REQ-028 reset asserted mid-EXEC SHALL abandon the instruction with no flag update or count increment.

Configuration
REQ-029 With SEQ_SINGLE_STEP_EN defined, input step (1 bit) SHALL exist:
  - a 0->1 edge of step in IDLE with run=0 SHALL execute exactly one instruction, then return to IDLE;
  - the edge register SHALL reset to 0.
REQ-030 Without SEQ_SINGLE_STEP_EN, the step port SHALL be absent and IDLE SHALL leave only via run or halt_req.

Structure
REQ-031 Package nibbler_pkg SHALL hold the state enum, the memory-opcode constants and the WAIT_MAX default.
REQ-032 The wait counter and its timeout compare SHALL be sub-module seq_wait_timer.

Verification
REQ-033 Reset then run=1 with instr_in=0xA3 (ADDI): phase 0,1 over 2 clocks; opcode=0xA, operand=0x3; instr_count=1.
REQ-034 instr_in=0x65 (LD) with mem_ready low for 3 cycles: EXEC lasts 4 clocks; ctrl_en=0,0,0,1; instr_count increments once.
REQ-035 instr_in=0x27 with load_flag=1, c_in=1, z_in=0: flag_c=1, flag_z=0 after EXEC; a following JMP with load_flag=0 leaves the flags held.
REQ-036 mem_ready held low on opcode 0xB with WAIT_MAX=15: timeout_err=1 and halted=1 after 16 stalled EXEC cycles; only reset recovers.
REQ-037 halt_req pulsed during FETCH: the instruction completes, then HALT; instr_count increments by 1.
REQ-038 With SEQ_SINGLE_STEP_EN and run=0: 3 step pulses give instr_count=3 and the block returns to IDLE after each.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types and constants for the nibbler instruction sequencer.
package nibbler_pkg;

    localparam int WAIT_MAX_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_MEM_A = 4'd3;
    localparam logic [3:0] OP_MEM_B = 4'd6;
    localparam logic [3:0] OP_MEM_C = 4'd7;
    localparam logic [3:0] OP_MEM_D = 4'd11;
    localparam logic [3:0] OP_MEM_E = 4'd15;

    // Memory opcodes wait on the RAM handshake during execute.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_MEM_A) || (op == OP_MEM_B) || (op == OP_MEM_C) ||
               (op == OP_MEM_D) || (op == OP_MEM_E);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive memory-stall cycles and flags the cycle that reaches WAIT_MAX.
module seq_wait_timer
    import nibbler_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    output logic expired
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] count;

    // Any non-stalled cycle (completion, fetch, idle) restarts the count.
    always_ff @(posedge clock) begin
        if (reset || !stall) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = stall && (count == CW'(WAIT_MAX));

endmodule

// File: rtl/nibbler_sequencer.sv
// Fetch/execute sequencer for the nibbler CPU; optional single-step input
// enabled by defining SEQ_SINGLE_STEP_EN.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       halt_req,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [7:0] instr_in,
    input  logic       c_in,
    input  logic       z_in,
    input  logic       load_flag,
    input  logic       mem_ready,
    output logic       phase,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    output logic       flag_c,
    output logic       flag_z,
    output logic       ctrl_en,
    output logic       busy,
    output logic       halted,
    output logic       timeout_err,
    output logic [7:0] instr_count
);

    state_t state, state_next;
    logic   stall;
    logic   expired;
    logic   halt_pending;
    logic   step_rise;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clock) begin
        if (reset) step_q <= 1'b0;
        else       step_q <= step;
    end

    assign step_rise = step && !step_q;
`else
    assign step_rise = 1'b0;
`endif

    assign stall = (state == EXEC) && !ctrl_en;

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .stall   (stall),
        .expired (expired)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (halt_req)       state_next = HALT;
                else if (run)       state_next = FETCH;
                else if (step_rise) state_next = FETCH;
            end
            FETCH: state_next = EXEC;
            EXEC: begin
                if (ctrl_en) begin
                    if (halt_req || halt_pending) state_next = HALT;
                    else if (run)                 state_next = FETCH;
                    else                          state_next = IDLE;
                end else if (expired) begin
                    state_next = HALT;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        phase   = 1'b0;
        ctrl_en = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        case (state)
            FETCH: begin
                ctrl_en = 1'b1;
                busy    = 1'b1;
            end
            EXEC: begin
                phase   = 1'b1;
                busy    = 1'b1;
                ctrl_en = is_mem_op(opcode) ? mem_ready : 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // A halt request seen mid-instruction is remembered and acted on at the boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            opcode       <= '0;
            operand      <= '0;
            flag_c       <= 1'b0;
            flag_z       <= 1'b0;
            timeout_err  <= 1'b0;
            instr_count  <= '0;
            halt_pending <= 1'b0;
        end else if (state == FETCH) begin
            opcode       <= instr_in[7:4];
            operand      <= instr_in[3:0];
            halt_pending <= halt_pending || halt_req;
        end else if (state == EXEC) begin
            if (ctrl_en) begin
                instr_count <= instr_count + 8'd1;
                if (load_flag) begin
                    flag_c <= c_in;
                    flag_z <= z_in;
                end
            end else begin
                halt_pending <= halt_pending || halt_req;
                if (expired) timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed, table-driven bench for nibbler_sequencer (define SEQ_SINGLE_STEP_EN
// to also exercise single-step).
module tb_nibbler_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       halt_req;
    logic       step;
    logic [7:0] instr_in;
    logic       c_in;
    logic       z_in;
    logic       load_flag;
    logic       mem_ready;
    logic       phase;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       flag_c;
    logic       flag_z;
    logic       ctrl_en;
    logic       busy;
    logic       halted;
    logic       timeout_err;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    nibbler_sequencer #(.WAIT_MAX(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .halt_req    (halt_req),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .instr_in    (instr_in),
        .c_in        (c_in),
        .z_in        (z_in),
        .load_flag   (load_flag),
        .mem_ready   (mem_ready),
        .phase       (phase),
        .opcode      (opcode),
        .operand     (operand),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .ctrl_en     (ctrl_en),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    typedef struct {
        logic       run;
        logic [7:0] instr;
        logic       lf;
        logic       c;
        logic       z;
        logic       mr;
        logic       e_phase;
        logic       e_ctrl;
        logic       e_busy;
        logic [3:0] e_op;
        logic [3:0] e_opr;
        logic       e_fc;
        logic       e_fz;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        run       = 1'b0;
        halt_req  = 1'b0;
        step      = 1'b0;
        instr_in  = 8'h00;
        c_in      = 1'b0;
        z_in      = 1'b0;
        load_flag = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] i, input logic lf,
                                input logic c, input logic z, input logic mr,
                                input logic ph, input logic ce, input logic bz,
                                input logic [3:0] op, input logic [3:0] opr,
                                input logic fc, input logic fz, input logic [7:0] cnt);
        vec_t v;
        v.run = r; v.instr = i; v.lf = lf; v.c = c; v.z = z; v.mr = mr;
        v.e_phase = ph; v.e_ctrl = ce; v.e_busy = bz; v.e_op = op; v.e_opr = opr;
        v.e_fc = fc; v.e_fz = fz; v.e_cnt = cnt;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // run instr lf c z mr | phase ctrl busy op opr fc fz cnt  (outputs before the edge)
        vecs[0]  = mk(0, 8'hA3, 0, 0, 0, 0,  0, 0, 0, 4'h0, 4'h0, 0, 0, 8'd0); // idle
        vecs[1]  = mk(1, 8'hA3, 0, 0, 0, 0,  0, 0, 0, 4'h0, 4'h0, 0, 0, 8'd0); // idle -> fetch
        vecs[2]  = mk(1, 8'hA3, 0, 0, 0, 0,  0, 1, 1, 4'h0, 4'h0, 0, 0, 8'd0); // fetch ADDI
        vecs[3]  = mk(1, 8'hA3, 0, 0, 0, 0,  1, 1, 1, 4'hA, 4'h3, 0, 0, 8'd0); // exec ADDI
        vecs[4]  = mk(1, 8'h27, 0, 0, 0, 0,  0, 1, 1, 4'hA, 4'h3, 0, 0, 8'd1); // fetch 0x27
        vecs[5]  = mk(1, 8'h27, 1, 1, 0, 0,  1, 1, 1, 4'h2, 4'h7, 0, 0, 8'd1); // exec, load flags
        vecs[6]  = mk(1, 8'h80, 0, 0, 0, 0,  0, 1, 1, 4'h2, 4'h7, 1, 0, 8'd2); // fetch JMP
        vecs[7]  = mk(1, 8'h80, 0, 0, 1, 0,  1, 1, 1, 4'h8, 4'h0, 1, 0, 8'd2); // exec JMP, no load
        vecs[8]  = mk(1, 8'h65, 0, 0, 0, 0,  0, 1, 1, 4'h8, 4'h0, 1, 0, 8'd3); // fetch LD
        vecs[9]  = mk(1, 8'h65, 1, 0, 1, 0,  1, 0, 1, 4'h6, 4'h5, 1, 0, 8'd3); // stall 1
        vecs[10] = mk(1, 8'h65, 1, 0, 1, 0,  1, 0, 1, 4'h6, 4'h5, 1, 0, 8'd3); // stall 2
        vecs[11] = mk(1, 8'h65, 1, 0, 1, 0,  1, 0, 1, 4'h6, 4'h5, 1, 0, 8'd3); // stall 3
        vecs[12] = mk(0, 8'h65, 0, 0, 1, 1,  1, 1, 1, 4'h6, 4'h5, 1, 0, 8'd3); // ready, complete
        vecs[13] = mk(0, 8'h65, 0, 0, 0, 0,  0, 0, 0, 4'h6, 4'h5, 1, 0, 8'd4); // back to idle

        // Reset state, sampled while reset is still held.
        reset = 1'b1; run = 1'b1; halt_req = 1'b1; step = 1'b0; instr_in = 8'hFF;
        c_in = 1'b1; z_in = 1'b1; load_flag = 1'b1; mem_ready = 1'b1;
        tick();
        check("rst_phase", {7'd0, phase}, 8'd0);
        check("rst_ctrl_en", {7'd0, ctrl_en}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_halted", {7'd0, halted}, 8'd0);
        check("rst_timeout", {7'd0, timeout_err}, 8'd0);
        check("rst_fields", {opcode, operand}, 8'h00);
        check("rst_flags", {6'd0, flag_c, flag_z}, 8'd0);
        check("rst_count", instr_count, 8'd0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            run = vecs[i].run; instr_in = vecs[i].instr; load_flag = vecs[i].lf;
            c_in = vecs[i].c; z_in = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            check($sformatf("v%0d_phase", i), {7'd0, phase}, {7'd0, vecs[i].e_phase});
            check($sformatf("v%0d_ctrl_en", i), {7'd0, ctrl_en}, {7'd0, vecs[i].e_ctrl});
            check($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
            check($sformatf("v%0d_halted", i), {7'd0, halted}, 8'd0);
            check($sformatf("v%0d_fields", i), {opcode, operand}, {vecs[i].e_op, vecs[i].e_opr});
            check($sformatf("v%0d_flags", i), {6'd0, flag_c, flag_z}, {6'd0, vecs[i].e_fc, vecs[i].e_fz});
            check($sformatf("v%0d_count", i), instr_count, vecs[i].e_cnt);
            tick();
        end

        // halt_req pulsed during FETCH: instruction completes, then HALT.
        do_reset();
        run = 1'b1; instr_in = 8'h10;
        tick();                                   // now FETCH
        halt_req = 1'b1;
        tick();                                   // now EXEC
        halt_req = 1'b0;
        #1;
        check("hf_exec_phase", {7'd0, phase}, 8'd1);
        check("hf_exec_halted", {7'd0, halted}, 8'd0);
        tick();
        check("hf_halted", {7'd0, halted}, 8'd1);
        check("hf_count", instr_count, 8'd1);
        check("hf_halt_ctrl_en", {7'd0, ctrl_en}, 8'd0);
        tick();
        tick();
        check("hf_stays_halted", {7'd0, halted}, 8'd1);

        // halt_req in IDLE goes straight to HALT.
        do_reset();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("hi_halted", {7'd0, halted}, 8'd1);
        check("hi_count", instr_count, 8'd0);

        // Memory timeout: 16 stalled EXEC cycles, then HALT with timeout_err.
        do_reset();
        run = 1'b1; instr_in = 8'hB0; mem_ready = 1'b0;
        tick();
        tick();                                   // first stalled EXEC cycle
        for (int i = 0; i < 15; i++) tick();      // 16th stalled cycle
        check("to_not_yet_halted", {7'd0, halted}, 8'd0);
        check("to_still_exec", {7'd0, phase}, 8'd1);
        tick();
        check("to_halted", {7'd0, halted}, 8'd1);
        check("to_timeout_err", {7'd0, timeout_err}, 8'd1);
        check("to_count", instr_count, 8'd0);
        check("to_phase", {7'd0, phase}, 8'd0);
        mem_ready = 1'b1;
        tick();
        tick();
        check("to_no_recover", {7'd0, halted}, 8'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to_reset_halted", {7'd0, halted}, 8'd0);
        check("to_reset_err", {7'd0, timeout_err}, 8'd0);

        // Reset mid-EXEC abandons the instruction.
        do_reset();
        run = 1'b1; instr_in = 8'h00; mem_ready = 1'b1;
        tick();
        tick();
        tick();                                   // one instruction done, now FETCH
        check("rm_count_before", instr_count, 8'd1);
        instr_in = 8'h30; mem_ready = 1'b0; load_flag = 1'b1; c_in = 1'b1; z_in = 1'b1;
        tick();                                   // stalled EXEC
        mem_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_count", instr_count, 8'd0);
        check("rm_flags", {6'd0, flag_c, flag_z}, 8'd0);
        check("rm_idle_busy", {7'd0, busy}, 8'd0);
        load_flag = 1'b0; c_in = 1'b0; z_in = 1'b0;

        // instr_count wraps 255 -> 0.
        do_reset();
        run = 1'b1; instr_in = 8'h00;
        tick();
        for (int i = 0; i < 255; i++) begin
            tick();
            tick();
        end
        check("wrap_255", instr_count, 8'd255);
        tick();
        tick();
        check("wrap_0", instr_count, 8'd0);

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: three step pulses with run=0.
        do_reset();
        run = 1'b0; instr_in = 8'h12;
        for (int n = 1; n <= 3; n++) begin
            step = 1'b1;
            tick();                               // now FETCH
            step = 1'b0;
            check($sformatf("st%0d_fetch_busy", n), {7'd0, busy}, 8'd1);
            tick();                               // now EXEC
            check($sformatf("st%0d_exec_phase", n), {7'd0, phase}, 8'd1);
            tick();                               // back to IDLE
            check($sformatf("st%0d_idle_busy", n), {7'd0, busy}, 8'd0);
            check($sformatf("st%0d_count", n), instr_count, 8'(n));
            tick();
        end
        step = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("st_held_high", instr_count, 8'd4);
        check("st_held_idle", {7'd0, busy}, 8'd0);
`else
        // Without single-step, IDLE is left only through run or halt_req.
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        check("idle_holds_busy", {7'd0, busy}, 8'd0);
        check("idle_holds_count", instr_count, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
